signed_to_twos_complement: RTL and testbench



---
 rtl/signed_to_twos_complement.sv | 34 +++
 tb/tb_signed_to_twos_complement.sv | 107 ++++++++++
 2 files changed

// File: rtl/signed_to_twos_complement.sv
// rtl/signed_to_twos_complement.sv - registered 10-bit to 9-bit signed conversion with saturation flag
module signed_to_twos_complement (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] res_o,
    output logic [8:0] z,
    output logic       sat
);

    logic [8:0] z_next;
    logic       sat_next;

    // Top two bits disagree exactly when the value needs more than 9 bits;
    // the sign bit then picks which rail to clamp to.
    always_comb begin
        z_next   = res_o[8:0];
        sat_next = 1'b0;
        if (res_o[9] != res_o[8]) begin
            sat_next = 1'b1;
            z_next   = res_o[9] ? 9'h100 : 9'h0FF;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            z   <= 9'h000;
            sat <= 1'b0;
        end else begin
            z   <= z_next;
            sat <= sat_next;
        end
    end

endmodule

// File: tb/tb_signed_to_twos_complement.sv
// tb/tb_signed_to_twos_complement.sv - self-checking bench for signed_to_twos_complement
module tb_signed_to_twos_complement;

    logic       clk;
    logic       rst_n;
    logic [9:0] res_o;
    logic [8:0] z;
    logic       sat;

    int compared;
    int mismatched;

    signed_to_twos_complement dut (
        .clk   (clk),
        .rst_n (rst_n),
        .res_o (res_o),
        .z     (z),
        .sat   (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clamp the signed integer value into -256..255.
    function automatic void model(input logic [9:0] v, input bit rn,
                                  output logic [8:0] ez, output logic es);
        int s;
        int c;
        if (!rn) begin
            ez = 9'h000;
            es = 1'b0;
        end else begin
            s  = $signed(v);
            c  = (s > 255) ? 255 : ((s < -256) ? -256 : s);
            ez = 9'(c);
            es = (c != s);
        end
    endfunction

    task automatic check(input string tag, input logic [8:0] ez, input logic es);
        compared++;
        assert (z === ez) else begin
            mismatched++;
            $error("FAIL %s z: observed %h expected %h", tag, z, ez);
        end
        compared++;
        assert (sat === es) else begin
            mismatched++;
            $error("FAIL %s sat: observed %b expected %b", tag, sat, es);
        end
    endtask

    // Drive between edges, then sample 1 time unit after the active edge.
    task automatic step(input string tag, input logic [9:0] v, input bit rn);
        logic [8:0] ez;
        logic       es;
        @(negedge clk);
        res_o = v;
        rst_n = rn;
        model(v, rn, ez, es);
        @(posedge clk);
        #1;
        check(tag, ez, es);
    endtask

    logic [9:0] dir_vals [18];

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        res_o      = 10'h155;

        step("reset0", 10'h155, 1'b0);
        step("reset1", 10'h155, 1'b0);
        compared++;
        assert (z === 9'h000 && sat === 1'b0) else begin
            mismatched++;
            $error("FAIL reset_const observed z=%h sat=%b expected z=000 sat=0", z, sat);
        end
        step("release", 10'h155, 1'b1);
        compared++;
        assert (z === 9'h0FF && sat === 1'b1) else begin
            mismatched++;
            $error("FAIL release_const observed z=%h sat=%b expected z=0ff sat=1", z, sat);
        end

        dir_vals = '{10'h001, 10'h002, 10'h003, 10'h004, 10'h005,
                     10'h3FF, 10'h3FE, 10'h3FD, 10'h3FC, 10'h3FB,
                     10'h0FF, 10'h300, 10'h100, 10'h2FF,
                     10'h12C, 10'h2D4, 10'h1FF, 10'h200};
        foreach (dir_vals[i]) begin
            for (int k = 0; k < 3; k++) step($sformatf("dir_%h", dir_vals[i]), dir_vals[i], 1'b1);
        end
        step("zero", 10'h000, 1'b1);

        for (int i = 0; i < 300; i++) begin
            logic [9:0] rv;
            rv = 10'($urandom);
            step((i == 150) ? "mid_reset" : "rand", rv, (i != 150));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
